// File: rtl/uart_fifo_burst_ctrl_pkg.sv
// Shared definitions for the UART FIFO burst controller: FSM encoding,
// drop-counter width and its saturating increment.
package uart_fifo_burst_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam int DROP_CNT_W = 16;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == {DROP_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/uart_fifo_burst_ctrl_skid2.sv
// Two-entry output buffer between the FIFO read port and the stream.
// head is the oldest entry and drives the stream data directly.
module uart_fifo_burst_ctrl_skid2 #(
  parameter int DATA_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        count,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] tail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else if (clr) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= push_data;
          else               tail <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          // occupancy unchanged; the new word lands behind whatever remains
          if (count == 2'd2) begin
            head <= tail;
            tail <= push_data;
          end else begin
            head <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_fifo_burst_ctrl.sv
// UART byte gating into the 8->256 FIFO, fixed-length burst drain onto a
// valid/ready stream, and FIFO flush sequencing through its active-high rst.
module uart_fifo_burst_ctrl
  import uart_fifo_burst_ctrl_pkg::*;
#(
  parameter int WR_DATA_WIDTH  = 8,
  parameter int RD_DATA_WIDTH  = 256,
  parameter int RD_DEPTH_WIDTH = 5,
  parameter int BURST_LEN      = 4,
  parameter int FLUSH_CYCLES   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush_req,
  input  logic [WR_DATA_WIDTH-1:0]    rx_data,
  input  logic                        rx_valid,
  output logic [WR_DATA_WIDTH-1:0]    fifo_wr_data,
  output logic                        fifo_wr_en,
  input  logic                        fifo_wr_full,
  output logic                        fifo_rd_en,
  input  logic [RD_DATA_WIDTH-1:0]    fifo_rd_data,
  input  logic                        fifo_rd_empty,
  input  logic [RD_DEPTH_WIDTH:0]     fifo_rd_water_level,
  output logic                        fifo_rst,
  output logic [RD_DATA_WIDTH-1:0]    m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        m_last,
  output logic                        busy,
  output logic [DROP_CNT_W-1:0]       drop_cnt
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam int FL_W  = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0]        BL_CNT  = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]        BL_LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [RD_DEPTH_WIDTH:0] BL_LVL  = (RD_DEPTH_WIDTH + 1)'(BURST_LEN);
  localparam logic [FL_W-1:0]         FL_LAST = FL_W'(FLUSH_CYCLES - 1);

  state_t           state, state_nxt;
  logic [FL_W-1:0]  cnt;
  logic             flush_pend;
  logic [CNT_W-1:0] issue_cnt, beat_cnt;
  logic             inflight;
  logic [1:0]       buf_cnt, occ;
  logic             pop, drop, buf_clr;

  assign fifo_wr_data = rx_data;
  assign fifo_wr_en   = rx_valid & ~fifo_wr_full & (state != ST_FLUSH);
  assign drop         = rx_valid & (fifo_wr_full | (state == ST_FLUSH));

  assign fifo_rst = (state == ST_FLUSH);
  assign busy     = (state != ST_IDLE);
  assign m_valid  = (buf_cnt != 2'd0);
  assign m_last   = m_valid & (beat_cnt == BL_LAST);
  assign pop      = m_valid & m_ready;
  assign buf_clr  = (state == ST_FLUSH);

  // A beat leaving this cycle frees its slot, so reads keep up at one per cycle.
  assign occ        = buf_cnt + {1'b0, inflight} - {1'b0, pop};
  assign fifo_rd_en = (state == ST_BURST) & (issue_cnt < BL_CNT) & ~fifo_rd_empty & (occ < 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_FLUSH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (flush_req || flush_pend)          state_nxt = ST_FLUSH;
        else if (fifo_rd_water_level >= BL_LVL) state_nxt = ST_BURST;
      end
      ST_BURST: if (pop && (beat_cnt == BL_LAST)) state_nxt = ST_IDLE;
      ST_FLUSH: if (cnt == FL_LAST)               state_nxt = ST_IDLE;
      default:  state_nxt = ST_FLUSH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      flush_pend <= 1'b0;
      issue_cnt  <= '0;
      beat_cnt   <= '0;
      inflight   <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      cnt      <= (state == ST_FLUSH && state_nxt == ST_FLUSH) ? cnt + FL_W'(1) : '0;
      inflight <= fifo_rd_en;
      if (state == ST_FLUSH)                     flush_pend <= 1'b0;
      else if (state == ST_BURST && flush_req)   flush_pend <= 1'b1;
      if (state == ST_IDLE && state_nxt == ST_BURST) begin
        issue_cnt <= '0;
        beat_cnt  <= '0;
      end else begin
        if (fifo_rd_en) issue_cnt <= issue_cnt + CNT_W'(1);
        if (pop)        beat_cnt  <= beat_cnt + CNT_W'(1);
      end
      if (drop) drop_cnt <= sat_inc(drop_cnt);
    end
  end

  uart_fifo_burst_ctrl_skid2 #(
    .DATA_W(RD_DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (buf_clr),
    .push      (inflight),
    .push_data (fifo_rd_data),
    .pop       (pop),
    .count     (buf_cnt),
    .head      (m_data)
  );

endmodule
